integral_image_gen: RTL and testbench

//  Streaming integral-image generator: consumes 8-bit greyscale pixels in raster order and

---
 rtl/integral_image_gen.sv | 197 +++++++++++++++++++
 tb/tb_integral_image_gen.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/integral_image_gen.sv
// -----------------------------------------------------------------------------
// integral_image_gen
//  Streaming integral-image (summed-area table) generator. Consumes unsigned
//  greyscale pixels in raster order and produces one 32-bit integral word per
//  pixel: ii(x,y) = sum of p(i,j) for all i<=x, j<=y. The output side is a
//  single register with a valid/accept handshake that feeds the image-cache
//  loader's 32-bit fill port directly.
//
//  Optional feature (macro IIGEN_ZERO_BORDER_EN):
//   When defined, each frame is framed by a zero top row and a zero left
//   column, giving (IMG_WIDTH+1)x(IMG_HEIGHT+1) words. When undefined, the
//   block emits exactly IMG_WIDTH*IMG_HEIGHT words per frame.
//
//  Ports:
//   clk          in   sole clock, all state on posedge
//   resetn       in   asynchronous active-low reset
//   pix_in       in   pixel value, unsigned, PIX_WIDTH bits
//   pix_valid    in   pix_in is valid
//   pix_ready    out  pixel is accepted this cycle when pix_valid is high
//   data         out  32-bit integral word
//   data_ready   out  data is valid
//   data_wanted  in   loader accepts data this cycle
//   frame_done   out  1-cycle pulse after the last word of a frame is taken
// -----------------------------------------------------------------------------
module integral_image_gen #(
   parameter int IMG_WIDTH  = 640,
   parameter int IMG_HEIGHT = 480,
   parameter int PIX_WIDTH  = 8
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic [PIX_WIDTH-1:0] pix_in,
   input  logic                 pix_valid,
   output logic                 pix_ready,
   output logic [31:0]          data,
   output logic                 data_ready,
   input  logic                 data_wanted,
   output logic                 frame_done
);

   localparam int XW = $clog2(IMG_WIDTH);
   localparam int YW = $clog2(IMG_HEIGHT);
   localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);

   logic [31:0]   data_q, data_d;
   logic          data_ready_q, data_ready_d;
   logic          last_q, last_d;         // output register holds last word of frame
   logic          frame_done_q, frame_done_d;
   logic [XW-1:0] x_q, x_d;
   logic [YW-1:0] y_q, y_d;
   logic [31:0]   rowsum_q, rowsum_d;

   // Previous row's integral values, one per column.
   logic [31:0]   lb [IMG_WIDTH];

   logic          slot_free;
   logic          word_acc;
   logic          pix_acc;
   logic          x_last;
   logic          y_last;
   logic [31:0]   rs;
   logic [31:0]   ii;

`ifdef IIGEN_ZERO_BORDER_EN
   localparam int BW = $clog2(IMG_WIDTH + 1);
   localparam logic [BW-1:0] B_LAST = BW'(IMG_WIDTH);

   typedef enum logic [1:0] {S_BROW, S_BCOL, S_PIX} state_e;

   state_e        state_q, state_d;
   logic [BW-1:0] bcnt_q, bcnt_d;         // zero words emitted in current border row
`endif

   // Output register can take a new word when empty or being drained now.
   assign slot_free = !data_ready_q || data_wanted;
   assign word_acc  = data_ready_q && data_wanted;
`ifdef IIGEN_ZERO_BORDER_EN
   assign pix_ready = slot_free && (state_q == S_PIX);
`else
   assign pix_ready = slot_free;
`endif
   assign pix_acc   = pix_valid && pix_ready;
   assign x_last    = (x_q == X_LAST);
   assign y_last    = (y_q == Y_LAST);

   // Row 0 never reads the line buffer, so its uninitialised contents are harmless.
   assign rs = ((x_q == '0) ? 32'd0 : rowsum_q) + 32'(pix_in);
   assign ii = rs + ((y_q == '0) ? 32'd0 : lb[x_q]);

   assign data       = data_q;
   assign data_ready = data_ready_q;
   assign frame_done = frame_done_q;

   // NOTE: every signal assigned in this block gets a default first, so no
   // path leaves a value unassigned and no latch is inferred.
   always_comb begin
      data_d       = data_q;
      data_ready_d = data_ready_q;
      last_d       = last_q;
      x_d          = x_q;
      y_d          = y_q;
      rowsum_d     = rowsum_q;
      frame_done_d = word_acc && last_q;

      if (word_acc) begin
         data_ready_d = 1'b0;
      end

      // A new word loaded in the same cycle as the old one drains replaces it.
      if (pix_acc) begin
         data_d       = ii;
         data_ready_d = 1'b1;
         last_d       = x_last && y_last;
         rowsum_d     = rs;
         if (x_last) begin
            x_d = '0;
            y_d = y_last ? '0 : y_q + YW'(1);
         end else begin
            x_d = x_q + XW'(1);
         end
      end

`ifdef IIGEN_ZERO_BORDER_EN
      state_d = state_q;
      bcnt_d  = bcnt_q;
      case (state_q)
         S_BROW: begin
            if (slot_free) begin
               data_d       = '0;
               data_ready_d = 1'b1;
               last_d       = 1'b0;
               if (bcnt_q == B_LAST) begin
                  bcnt_d  = '0;
                  state_d = S_BCOL;
               end else begin
                  bcnt_d = bcnt_q + BW'(1);
               end
            end
         end
         S_BCOL: begin
            if (slot_free) begin
               data_d       = '0;
               data_ready_d = 1'b1;
               last_d       = 1'b0;
               state_d      = S_PIX;
            end
         end
         S_PIX: begin
            if (pix_acc && x_last) begin
               state_d = y_last ? S_BROW : S_BCOL;
            end
         end
         default: state_d = S_PIX;
      endcase
`endif
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         data_q       <= '0;
         data_ready_q <= 1'b0;
         last_q       <= 1'b0;
         frame_done_q <= 1'b0;
         x_q          <= '0;
         y_q          <= '0;
         rowsum_q     <= '0;
`ifdef IIGEN_ZERO_BORDER_EN
         state_q      <= S_BROW;
         bcnt_q       <= '0;
`endif
      end else begin
         data_q       <= data_d;
         data_ready_q <= data_ready_d;
         last_q       <= last_d;
         frame_done_q <= frame_done_d;
         x_q          <= x_d;
         y_q          <= y_d;
         rowsum_q     <= rowsum_d;
`ifdef IIGEN_ZERO_BORDER_EN
         state_q      <= state_d;
         bcnt_q       <= bcnt_d;
`endif
      end
   end

   // NOTE: the line buffer has no reset; clearing a RAM-sized array costs a
   // reset fan-out to every word and row 0 never reads it anyway.
   always_ff @(posedge clk) begin
      if (pix_acc) begin
         lb[x_q] <= ii;
      end
   end

endmodule

// File: tb/tb_integral_image_gen.sv
// -----------------------------------------------------------------------------
// tb_integral_image_gen
//  Directed self-checking bench for integral_image_gen with a 4x3 image.
//  Accepted output words are collected at the falling edge and compared
//  against hand-computed integral sequences.
// -----------------------------------------------------------------------------
module tb_integral_image_gen;

   localparam int W = 4;
   localparam int H = 3;

   logic        clk = 1'b0;
   logic        resetn;
   logic [7:0]  pix_in;
   logic        pix_valid;
   logic        pix_ready;
   logic [31:0] data;
   logic        data_ready;
   logic        data_wanted;
   logic        frame_done;

   int vectors = 0;
   int errors  = 0;
   int fd_cnt  = 0;
   logic [31:0] got [$];

   logic [31:0] exp1 [12] = '{1, 2, 3, 4, 2, 4, 6, 8, 3, 6, 9, 12};
   logic [31:0] exp4 [12] = '{0, 1, 3, 6, 1, 4, 9, 16, 3, 9, 18, 30};
   logic [31:0] exp2 [12];
`ifdef IIGEN_ZERO_BORDER_EN
   logic [31:0] exp6 [20] = '{0, 0, 0, 0, 0,  0, 1, 2, 3, 4,
                              0, 2, 4, 6, 8,  0, 3, 6, 9, 12};
`endif

   always #5 clk = ~clk;

   integral_image_gen #(
      .IMG_WIDTH  (W),
      .IMG_HEIGHT (H),
      .PIX_WIDTH  (8)
   ) dut (
      .clk         (clk),
      .resetn      (resetn),
      .pix_in      (pix_in),
      .pix_valid   (pix_valid),
      .pix_ready   (pix_ready),
      .data        (data),
      .data_ready  (data_ready),
      .data_wanted (data_wanted),
      .frame_done  (frame_done)
   );

   // Inputs change only 1 time unit after posedge, so the falling edge sees
   // exactly the handshake that the next rising edge will act on.
   always @(negedge clk) begin
      if (data_ready && data_wanted) got.push_back(data);
      if (frame_done) fd_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      vectors++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   function automatic logic [31:0] got_at(input int i);
      if (i < got.size()) return got[i];
      return 32'hxxxx_xxxx;
   endfunction

   task automatic check_frame(input string tag, input logic [31:0] e [12], input int base);
      for (int i = 0; i < 12; i++) begin
         check($sformatf("%s[%0d]", tag, i), got_at(base + i), e[i]);
      end
   endtask

   // Offer one pixel and hold it until taken, bounded to 50 cycles.
   task automatic send_pix(input logic [7:0] p);
      int n;
      n         = 0;
      pix_in    = p;
      pix_valid = 1'b1;
      @(negedge clk);
      while (!pix_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!pix_ready) begin
         check("pix_accept_timeout", 32'(n), 32'd0);
      end
      @(posedge clk);
      #1;
      pix_valid = 1'b0;
   endtask

   task automatic settle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 12; i++) exp2[i] = exp1[i] * 32'd255;

      resetn      = 1'b0;
      pix_valid   = 1'b0;
      pix_in      = '0;
      data_wanted = 1'b1;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_data_ready", 32'(data_ready), 32'd0);
      check("rst_data",       data,            32'd0);
      check("rst_frame_done", 32'(frame_done), 32'd0);
`ifdef IIGEN_ZERO_BORDER_EN
      check("rst_pix_ready",  32'(pix_ready),  32'd0);
`else
      check("rst_pix_ready",  32'(pix_ready),  32'd1);
`endif
      @(posedge clk);
      #1;
      resetn = 1'b1;

`ifdef IIGEN_ZERO_BORDER_EN
      // Test 6: zero border, all-ones frame
      got.delete();
      fd_cnt = 0;
      repeat (W * H) send_pix(8'd1);
      settle(4);
      check("t6_count_ge20", 32'(got.size() >= 20), 32'd1);
      for (int i = 0; i < 20; i++) begin
         check($sformatf("t6[%0d]", i), got_at(i), exp6[i]);
      end
      check("t6_frame_done", 32'(fd_cnt), 32'd1);
`else
      // Test 1: all-ones frame, including first-word latency
      got.delete();
      fd_cnt = 0;
      send_pix(8'd1);
      check("t1_latency_ready", 32'(data_ready), 32'd1);
      check("t1_latency_data",  data,            32'd1);
      repeat (W * H - 1) send_pix(8'd1);
      settle(4);
      check("t1_count", 32'(got.size()), 32'd12);
      check_frame("t1", exp1, 0);
      check("t1_frame_done", 32'(fd_cnt), 32'd1);
      check("t1_drained", 32'(data_ready), 32'd0);

      // Test 2: all-255 frame
      got.delete();
      fd_cnt = 0;
      repeat (W * H) send_pix(8'd255);
      settle(4);
      check("t2_count", 32'(got.size()), 32'd12);
      check_frame("t2", exp2, 0);
      check("t2_last", got_at(11), 32'd3060);
      check("t2_frame_done", 32'(fd_cnt), 32'd1);

      // Test 3: 5-cycle stall mid-row with a pixel waiting
      got.delete();
      fd_cnt = 0;
      repeat (6) send_pix(8'd1);
      data_wanted = 1'b0;
      pix_in      = 8'd1;
      pix_valid   = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check($sformatf("t3_hold_ready[%0d]", k), 32'(data_ready), 32'd1);
         check($sformatf("t3_hold_data[%0d]", k),  data,            32'd4);
         check($sformatf("t3_pix_ready[%0d]", k),  32'(pix_ready),  32'd0);
         @(posedge clk);
         #1;
      end
      data_wanted = 1'b1;
      repeat (6) send_pix(8'd1);
      settle(4);
      check("t3_count", 32'(got.size()), 32'd12);
      check_frame("t3", exp1, 0);
      check("t3_frame_done", 32'(fd_cnt), 32'd1);

      // Test 4: two back-to-back frames of pixel = x + y
      got.delete();
      fd_cnt = 0;
      for (int f = 0; f < 2; f++) begin
         for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
               send_pix(8'(x + y));
            end
         end
      end
      settle(4);
      check("t4_count", 32'(got.size()), 32'd24);
      check_frame("t4_f0", exp4, 0);
      check_frame("t4_f1", exp4, 12);
      check("t4_frame_done", 32'(fd_cnt), 32'd2);

      // Test 5: reset mid-frame, then a clean all-ones frame
      repeat (6) send_pix(8'd1);
      resetn = 1'b0;
      @(negedge clk);
      check("t5_rst_data_ready", 32'(data_ready), 32'd0);
      check("t5_rst_data",       data,            32'd0);
      check("t5_rst_pix_ready",  32'(pix_ready),  32'd1);
      settle(2);
      resetn = 1'b1;
      got.delete();
      fd_cnt = 0;
      repeat (W * H) send_pix(8'd1);
      settle(4);
      check("t5_count", 32'(got.size()), 32'd12);
      check_frame("t5", exp1, 0);
      check("t5_frame_done", 32'(fd_cnt), 32'd1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
